// File: rtl/gerador_menor_5_pkg.sv
// Shared definitions for the gerador_menor_5 comparator sweep source:
// state encoding, widths and the default handshake timeout.
package gerador_menor_5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

  localparam int VAL_W           = 4;
  localparam int CNT_W           = 5;
  localparam int WAIT_W          = 8;
  localparam int TIMEOUT_DEFAULT = 8;

  // Sweep values wrap 15 -> 0 through the natural 4-bit overflow.
  function automatic logic [VAL_W-1:0] next_val(input logic [VAL_W-1:0] v);
    return v + VAL_W'(1);
  endfunction

endpackage

// File: rtl/gerador_menor_5_contador_espera.sv
// TIMEOUT-bounded wait counter: counts stalled handshake cycles and flags
// expirou once the final permitted stall cycle has been reached.
module contador_espera
  import gerador_menor_5_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expirou_o
);

  logic [WAIT_W-1:0] espera_q;
  logic [WAIT_W-1:0] espera_d;

  // Saturates at TIMEOUT-1; the owner aborts on that cycle, so it never wraps.
  always_comb begin
    espera_d = espera_q;
    if (clear_i) begin
      espera_d = '0;
    end else if (enable_i && !expirou_o) begin
      espera_d = espera_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      espera_q <= '0;
    end else begin
      espera_q <= espera_d;
    end
  end

  assign expirou_o = (espera_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/gerador_menor_5.sv
// Sweep source for a 4-bit threshold comparator: emits inicio..fim (mod 16)
// on a valid/ready interface and counts how many values returned s_in=1.
module gerador_menor_5
  import gerador_menor_5_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] inicio,
  input  logic [VAL_W-1:0] fim,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             valid,
  input  logic             ready,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic [CNT_W-1:0] contagem,
  output logic [1:0]       estado_dbg
);

  // Handshake: a value transfers on every rising clock edge where valid and
  // ready are both high; {a,b,c,d} stays constant while valid waits for ready.

  estado_t          state_q, state_d;
  logic [VAL_W-1:0] cur_q, cur_d;
  logic [VAL_W-1:0] fim_q, fim_d;
  logic [CNT_W-1:0] contagem_q, contagem_d;
  logic             erro_q, erro_d;
  logic             armed_q;
  logic             clear_wait;
  logic             en_wait;
  logic             expirou;

  contador_espera #(
    .TIMEOUT (TIMEOUT)
  ) u_espera (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clear_i   (clear_wait),
    .enable_i  (en_wait),
    .expirou_o (expirou)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    fim_d      = fim_q;
    contagem_d = contagem_q;
    erro_d     = erro_q;
    clear_wait = 1'b0;
    en_wait    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q blocks a start that coincides with the reset-release edge.
        if (start && armed_q) begin
          cur_d      = inicio;
          fim_d      = fim;
          contagem_d = '0;
          erro_d     = 1'b0;
          clear_wait = 1'b1;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (ready) begin
          contagem_d = contagem_q + CNT_W'(s_in);
          clear_wait = 1'b1;
          if (cur_q == fim_q) begin
            state_d = ST_DONE;
          end else begin
            cur_d = next_val(cur_q);
          end
        end else if (expirou) begin
          erro_d     = 1'b1;
          clear_wait = 1'b1;
          state_d    = ST_DONE;
        end else begin
          en_wait = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      fim_q      <= '0;
      contagem_q <= '0;
      erro_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      fim_q      <= fim_d;
      contagem_q <= contagem_d;
      erro_q     <= erro_d;
      armed_q    <= 1'b1;
    end
  end

  assign {a, b, c, d} = cur_q;
  assign valid        = (state_q == ST_EMIT);
  assign busy         = (state_q == ST_EMIT);
  assign done         = (state_q == ST_DONE);
  assign erro         = erro_q;
  assign contagem     = contagem_q;
  assign estado_dbg   = state_q;

endmodule
